// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch (I) and data (D) requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed D priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       cmd_we;
    logic       grant_d;
    logic       grant_any;
    logic       grant_store;

`ifdef MEM_ARB_RR_EN
    // 1 = D was granted last; on a tie the other side wins.
    logic last_grant_d;

    always_comb grant_d = d_req & (~i_req | ~last_grant_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant_d <= 1'b0;
        else if (state == IDLE && grant_any)
            last_grant_d <= grant_d;
    end
`else
    always_comb grant_d = d_req;
`endif

    always_comb grant_any   = i_req | d_req;
    always_comb grant_store = grant_d & d_we;

    // Memory strobes are registered, so they are set one edge ahead of the BUSY cycle they mark.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        cmd_we    <= grant_store;
                        cnt       <= CNT_LOAD;
                        mem_read  <= ~grant_store;
                        mem_write <= grant_store & (CNT_LOAD == 4'd0);
                        busy      <= 1'b1;
                        state     <= grant_d ? BUSY_D : BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (cnt == 4'd0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                            state   <= RESP_I;
                        end else begin
                            if (!cmd_we)
                                d_rdata <= mem_rdata;
                            d_done <= 1'b1;
                            state  <= RESP_D;
                        end
                    end else begin
                        cnt       <= cnt - 4'd1;
                        mem_write <= cmd_we & (cnt == 4'd1);
                    end
                end
                RESP_I, RESP_D: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency backing memory between the instruction-fetch side (I, read-only) and the data-access side (D, read/write) of the 5-stage pipelined core.
- Sequences each access through a small FSM and a latency counter.
- Holds the memory command stable for the whole access and returns read data with a one-cycle done pulse.
- The core stalls the affected stage on `*_req & ~*_done`.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LATENCY, 4, cycles the memory command must be held before read data is valid; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_done  out  1  one-cycle pulse; fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DATA_W  load data.
- mem_addr  out  ADDR_W  backing-memory address.
- mem_wdata  out  DATA_W  backing-memory write data.
- mem_read  out  1  read command.
- mem_write  out  1  write strobe.
- mem_rdata  in  DATA_W  backing-memory read data; valid on the last held cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-access):
  - FSM goes to IDLE; counter = 0.
  - All outputs = 0, including rdata registers.
  - An in-flight access is dropped and no done pulse is produced for it; requesters must re-present after reset.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Samples i_req and d_req.
  - Both high → D granted (fixed priority; the older instruction is in MEM).
  - Only one high → that side is granted.
  - Neither high → stay in IDLE.
  - On grant: latch address, wdata and we into command registers; load counter = MEM_LATENCY-1; go to BUSY_x.
- BUSY_x:
  - mem_addr/mem_wdata come from the command registers.
  - mem_read = 1 for reads, for every BUSY cycle.
  - mem_write = 1 only in the final BUSY cycle (counter == 0), so exactly one write per store.
  - Counter decrements each cycle.
  - At counter == 0: capture mem_rdata into x_rdata (loads/fetches only; stores leave d_rdata unchanged), then go to RESP_x.
- RESP_x:
  - x_done = 1 for this cycle only; mem_read and mem_write = 0; next state IDLE.
  - The requester drops req on the edge it sees done; a req still high in IDLE is treated as a new request.
- Latency from req rising (sampled in IDLE) to done: MEM_LATENCY+1 cycles.
  - A loser waits out the full winner access plus RESP before it is granted.
  - MEM_LATENCY=1 → BUSY lasts exactly one cycle.
- Request changes while the other side is busy are ignored until IDLE; a request dropped before grant is never served.
- A write and a read never overlap; at most one access is outstanding.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin using a 1-bit last_grant register (reset value = I).
  - On a simultaneous request, the side not granted last wins.
  - last_grant updates on every grant.
- Undefined: fixed D priority as above, and no last_grant register exists.

Test Plan:
- MEM_LATENCY=4, i_req=1, i_addr=0x10, memory word = 0xDEADBEEF → mem_read high 4 cycles; i_done pulses in cycle 5; i_rdata=0xDEADBEEF; d_done stays 0.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0x1234 → mem_write high exactly one cycle (the 4th BUSY cycle), addr 0x20; d_done in cycle 5; a following load of 0x20 returns 0x1234.
- i_req and d_req rise in the same cycle:
  - Fixed mode: D served first (d_done at cycle 5), then I (i_done at cycle 11).
  - MEM_ARB_RR_EN with last_grant reset to I: D first.
  - MEM_ARB_RR_EN, repeated: alternates D, I, D, I.
- d_req held high continuously with i_req pending:
  - Fixed mode: I starves while D re-requests.
  - MEM_ARB_RR_EN: I granted every second access.
- reset driven low during the 2nd BUSY cycle of a load, released 2 cycles later → all outputs 0 immediately (asynchronously), no d_done, FSM in IDLE; re-issued load completes normally.
- MEM_LATENCY=1, back-to-back fetches 0x0 and 0x4 → each i_done 2 cycles after grant; IDLE cycle between accesses; rdata correct for both.
